// File: rtl/mips_bus_pkg.sv
// ============================================================================
// mips_bus_pkg : shared types and constants for the data-memory arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_bus_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DMA  = 1'b1
  } arb_state_t;

  localparam logic [31:0] WORD_STRIDE = 32'd4;
  localparam int          BLEN_W      = 4;

  // Index of the final beat: length 0 means one beat, lengths above bmax clamp to bmax.
  function automatic logic [BLEN_W-1:0] last_beat(input logic [BLEN_W-1:0] len,
                                                  input logic [BLEN_W:0]   bmax);
    logic [BLEN_W:0] w_lm1;
    if (len == '0) return '0;
    if ({1'b0, len} > bmax) begin
      w_lm1 = bmax - 1'b1;
      return w_lm1[BLEN_W-1:0];
    end
    return len - 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_starve_cnt.sv
// ============================================================================
// arb_starve_cnt : saturating count of cycles a DMA request lost to the CPU
// Rev 1.0
// ============================================================================
`default_nettype none

module arb_starve_cnt #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_full
);

  localparam logic [7:0] c_max = 8'(MAX_WAIT);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_full = (r_cnt == c_max);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : CPU-priority arbiter for the data-memory port with DMA bursts.
// Build option: ARB_BURST_EN enables multi-beat bursts (else single-beat grants).
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import mips_bus_pkg::*;
#(
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpuCe,
  input  logic        cpuWr,
  input  logic [31:0] cpuAddr,
  input  logic [31:0] cpuWtData,
  output logic [31:0] cpuRdData,
  output logic        cpuStall,
  input  logic        dmaReq,
  input  logic        dmaWr,
  input  logic [31:0] dmaAddr,
  input  logic [3:0]  dmaLen,
  input  logic [31:0] dmaWtData,
  output logic        dmaGnt,
  output logic        dmaValid,
  output logic [31:0] dmaRdData,
  output logic        dmaDone,
  output logic        memCe,
  output logic        memWr,
  output logic [31:0] memAddr,
  output logic [31:0] memWtData,
  input  logic [31:0] memRdData
);

  arb_state_t  r_state;
  logic [31:0] r_base;
  logic        r_wr;
  logic        r_valid;
  logic        r_done;
  logic [31:0] r_rd;

  logic        w_dma;
  logic        w_full;
  logic        w_start;
  logic        w_inc;
  logic        w_clr;
  logic        w_lastBeat;
  logic [31:0] w_addr;

  assign w_dma = (r_state == ST_DMA);
  // dmaReq is ignored in the dmaDone cycle so a lingering request cannot re-arm.
  assign w_start = !w_dma && dmaReq && !r_done && (!cpuCe || w_full);
  assign w_inc   = !w_dma && dmaReq && cpuCe && !r_done;
  assign w_clr   = !dmaReq || w_start;

  arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_full (w_full)
  );

`ifdef ARB_BURST_EN
  logic [BLEN_W-1:0] r_beat;
  logic [BLEN_W-1:0] r_last;
  assign w_lastBeat = (r_beat == r_last);
  assign w_addr     = r_base + WORD_STRIDE * 32'(r_beat);
`else
  logic w_unused_len;
  assign w_unused_len = ^dmaLen;
  assign w_lastBeat   = 1'b1;
  assign w_addr       = r_base;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_base  <= '0;
      r_wr    <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_rd    <= '0;
`ifdef ARB_BURST_EN
      r_beat  <= '0;
      r_last  <= '0;
`endif
    end else begin
      r_valid <= w_dma;
      r_done  <= w_dma && w_lastBeat;
      if (w_dma) r_rd <= memRdData;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_DMA;
            r_base  <= dmaAddr;
            r_wr    <= dmaWr;
`ifdef ARB_BURST_EN
            r_beat  <= '0;
            r_last  <= last_beat(dmaLen, (BLEN_W+1)'(BURST_MAX));
`endif
          end
        end
        ST_DMA: begin
          if (w_lastBeat) r_state <= ST_IDLE;
`ifdef ARB_BURST_EN
          r_beat <= w_lastBeat ? '0 : r_beat + 1'b1;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dmaGnt    = w_dma;
  assign dmaValid  = r_valid;
  assign dmaDone   = r_done;
  assign dmaRdData = r_rd;
  assign memCe     = w_dma ? 1'b1      : cpuCe;
  assign memWr     = w_dma ? r_wr      : cpuWr;
  assign memAddr   = w_dma ? w_addr    : cpuAddr;
  assign memWtData = w_dma ? dmaWtData : cpuWtData;
  assign cpuRdData = w_dma ? 32'h0     : memRdData;
  assign cpuStall  = w_dma && cpuCe;

endmodule

`default_nettype wire
